// File: rtl/aes_tlul_txn_tracker_if.sv
// TL-UL A/D channel bundle as seen on the aes bus port.
// The host/device side drives it through master; the passive tracker only observes it through slave.
interface aes_tlul_txn_tracker_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int SRC_WIDTH  = 8
);
    logic                    a_valid;
    logic                    a_ready;
    logic [2:0]              a_opcode;
    logic [ADDR_WIDTH-1:0]   a_address;
    logic [DATA_WIDTH-1:0]   a_data;
    logic [DATA_WIDTH/8-1:0] a_mask;
    logic [SRC_WIDTH-1:0]    a_source;
    logic                    d_valid;
    logic                    d_ready;
    logic [2:0]              d_opcode;
    logic [DATA_WIDTH-1:0]   d_data;
    logic [SRC_WIDTH-1:0]    d_source;
    logic                    d_error;

    modport master (
        output a_valid, a_ready, a_opcode, a_address, a_data, a_mask, a_source,
        output d_valid, d_ready, d_opcode, d_data, d_source, d_error
    );

    modport slave (
        input a_valid, a_ready, a_opcode, a_address, a_data, a_mask, a_source,
        input d_valid, d_ready, d_opcode, d_data, d_source, d_error
    );
endinterface

// File: rtl/aes_tlul_txn_tracker.sv
// Passive TL-UL tracker: pairs A requests with in-order D responses and pulses wr/rd/err events.
// Events appear 1 cycle after the D accept; the bus is only observed, never backpressured.
module aes_tlul_txn_tracker #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int SRC_WIDTH  = 8,
    parameter int DEPTH      = 2,
    localparam int MW = DATA_WIDTH / 8,
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    aes_tlul_txn_tracker_if.slave bus,
    output logic                  wr_o,
    output logic                  rd_o,
    output logic                  err_o,
    output logic [ADDR_WIDTH-1:0] addr_o,
    output logic [DATA_WIDTH-1:0] wdata_o,
    output logic [MW-1:0]         wmask_o,
    output logic [DATA_WIDTH-1:0] rdata_o,
    output logic [CW-1:0]         outstanding_o,
    output logic                  proto_err_o,
    output logic [1:0]            proto_code_o
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef struct packed {
        logic [2:0]            opcode;
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] data;
        logic [MW-1:0]         mask;
        logic [SRC_WIDTH-1:0]  source;
    } entry_t;

    entry_t        q [DEPTH];
    entry_t        head;
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count;

    logic a_acc, d_acc, a_legal, empty, full, head_put;
    logic pop, push, good, v1, v2, v3;

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        a_acc    = bus.a_valid && bus.a_ready;
        d_acc    = bus.d_valid && bus.d_ready;
        a_legal  = (bus.a_opcode == 3'd0) || (bus.a_opcode == 3'd1) || (bus.a_opcode == 3'd4);
        empty    = (count == '0);
        full     = (count == CW'(DEPTH));
        head     = q[rd_ptr];
        head_put = (head.opcode != 3'd4);
        // Response is judged against the head as it stood before any same-cycle push.
        pop      = d_acc && !empty;
        v1       = d_acc && empty;
        v2       = pop && ((bus.d_source != head.source) ||
                           ( head_put && bus.d_opcode != 3'd0) ||
                           (!head_put && bus.d_opcode != 3'd1));
        good     = pop && !v2;
        push     = a_acc && a_legal && (!full || pop);
        v3       = a_acc && (!a_legal || (full && !pop));
    end

    always_ff @(posedge clk_i) begin
        if (push) begin
            q[wr_ptr] <= '{opcode: bus.a_opcode, addr: bus.a_address, data: bus.a_data,
                           mask: bus.a_mask, source: bus.a_source};
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= next_ptr(wr_ptr);
            if (pop)  rd_ptr <= next_ptr(rd_ptr);
            if (push && !pop)      count <= count + 1'b1;
            else if (pop && !push) count <= count - 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_o    <= 1'b0;
            rd_o    <= 1'b0;
            err_o   <= 1'b0;
            addr_o  <= '0;
            wdata_o <= '0;
            wmask_o <= '0;
            rdata_o <= '0;
        end else begin
            wr_o  <= 1'b0;
            rd_o  <= 1'b0;
            err_o <= 1'b0;
            if (good) begin
                err_o   <= bus.d_error;
                wr_o    <= !bus.d_error && head_put;
                rd_o    <= !bus.d_error && !head_put;
                addr_o  <= head.addr;
                wdata_o <= head_put ? head.data : '0;
                wmask_o <= head_put ? head.mask : '0;
                rdata_o <= head_put ? '0 : bus.d_data;
            end
        end
    end

    // Only the first violation is latched; lower codes win within a cycle.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            proto_err_o  <= 1'b0;
            proto_code_o <= 2'd0;
        end else if (!proto_err_o && (v1 || v2 || v3)) begin
            proto_err_o  <= 1'b1;
            proto_code_o <= v1 ? 2'd1 : (v2 ? 2'd2 : 2'd3);
        end
    end

    assign outstanding_o = count;
endmodule

// File: tb/tb_aes_tlul_txn_tracker.sv
// Directed bench for aes_tlul_txn_tracker with DEPTH=2; each scenario task checks its own results.
module tb_aes_tlul_txn_tracker;
    localparam int AW = 32, DW = 32, SW = 8, DEPTH = 2;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    aes_tlul_txn_tracker_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .SRC_WIDTH(SW)) bus ();

    logic          wr, rd, err, proto_err;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata, rdata;
    logic [3:0]    wmask;
    logic [1:0]    outstanding;
    logic [1:0]    proto_code;

    aes_tlul_txn_tracker #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .SRC_WIDTH(SW), .DEPTH(DEPTH)) dut (
        .clk_i(clk), .rst_ni(rst_n), .bus(bus),
        .wr_o(wr), .rd_o(rd), .err_o(err), .addr_o(addr),
        .wdata_o(wdata), .wmask_o(wmask), .rdata_o(rdata),
        .outstanding_o(outstanding), .proto_err_o(proto_err), .proto_code_o(proto_code)
    );

    int checks = 0;
    int passed = 0;

    task automatic idle_bus();
        bus.a_valid = 0; bus.a_ready = 1; bus.a_opcode = 0; bus.a_address = 0;
        bus.a_data = 0; bus.a_mask = 0; bus.a_source = 0;
        bus.d_valid = 0; bus.d_ready = 1; bus.d_opcode = 0; bus.d_data = 0;
        bus.d_source = 0; bus.d_error = 0;
    endtask

    task automatic set_a(input logic [2:0] op, input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] m, input logic [7:0] s);
        bus.a_valid = 1; bus.a_opcode = op; bus.a_address = a;
        bus.a_data = d; bus.a_mask = m; bus.a_source = s;
    endtask

    task automatic set_d(input logic [2:0] op, input logic [31:0] d, input logic [7:0] s,
                         input logic e);
        bus.d_valid = 1; bus.d_opcode = op; bus.d_data = d; bus.d_source = s; bus.d_error = e;
    endtask

    // Finish the cycle: wait for the edge, sample 1ns later, then drop valids.
    task automatic step();
        @(posedge clk); #1;
        bus.a_valid = 0; bus.d_valid = 0;
    endtask

    task automatic drive_a(input logic [2:0] op, input logic [31:0] a, input logic [31:0] d,
                           input logic [3:0] m, input logic [7:0] s);
        set_a(op, a, d, m, s); step();
    endtask

    task automatic drive_d(input logic [2:0] op, input logic [31:0] d, input logic [7:0] s,
                           input logic e);
        set_d(op, d, s, e); step();
    endtask

    task automatic do_reset();
        idle_bus();
        rst_n = 0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if ({wr, rd, err} !== 3'b000) $display("FAIL reset_pulses got %b want 000", {wr, rd, err}); else passed++;
        checks++; if (outstanding !== 2'd0) $display("FAIL reset_outstanding got %0d want 0", outstanding); else passed++;
        checks++; if ({proto_err, proto_code} !== 3'b000) $display("FAIL reset_proto got %b want 000", {proto_err, proto_code}); else passed++;
        checks++; if ({addr, wdata, wmask, rdata} !== '0) $display("FAIL reset_data got %h want 0", {addr, wdata, wmask, rdata}); else passed++;
    endtask

    task automatic test_read();
        do_reset();
        drive_a(3'd4, 32'h10, 32'h0, 4'h0, 8'd3);
        checks++; if (outstanding !== 2'd1) $display("FAIL rd_outstanding1 got %0d want 1", outstanding); else passed++;
        step();
        drive_d(3'd1, 32'hCAFE_F00D, 8'd3, 1'b0);
        checks++; if ({wr, rd, err} !== 3'b010) $display("FAIL rd_pulse got %b want 010", {wr, rd, err}); else passed++;
        checks++; if (addr !== 32'h10) $display("FAIL rd_addr got %h want 00000010", addr); else passed++;
        checks++; if (rdata !== 32'hCAFE_F00D) $display("FAIL rd_rdata got %h want cafef00d", rdata); else passed++;
        checks++; if ({wdata, wmask} !== '0) $display("FAIL rd_wdata_zero got %h want 0", {wdata, wmask}); else passed++;
        checks++; if (outstanding !== 2'd0) $display("FAIL rd_outstanding0 got %0d want 0", outstanding); else passed++;
        step();
        checks++; if (rd !== 1'b0) $display("FAIL rd_one_cycle got %b want 0", rd); else passed++;
        checks++; if (addr !== 32'h10) $display("FAIL rd_addr_hold got %h want 00000010", addr); else passed++;
    endtask

    task automatic test_write();
        do_reset();
        drive_a(3'd0, 32'h20, 32'h1234, 4'hF, 8'd1);
        drive_d(3'd0, 32'hFFFF_FFFF, 8'd1, 1'b0);
        checks++; if ({wr, rd, err} !== 3'b100) $display("FAIL wr_pulse got %b want 100", {wr, rd, err}); else passed++;
        checks++; if (addr !== 32'h20) $display("FAIL wr_addr got %h want 00000020", addr); else passed++;
        checks++; if (wdata !== 32'h1234) $display("FAIL wr_wdata got %h want 00001234", wdata); else passed++;
        checks++; if (wmask !== 4'hF) $display("FAIL wr_wmask got %h want f", wmask); else passed++;
        checks++; if (rdata !== 32'h0) $display("FAIL wr_rdata_zero got %h want 0", rdata); else passed++;
        checks++; if (proto_err !== 1'b0) $display("FAIL wr_no_proto got %b want 0", proto_err); else passed++;
    endtask

    task automatic test_error_resp();
        do_reset();
        drive_a(3'd1, 32'h24, 32'hAB, 4'h3, 8'd2);
        drive_d(3'd0, 32'h0, 8'd2, 1'b1);
        checks++; if ({wr, rd, err} !== 3'b001) $display("FAIL errresp_pulse got %b want 001", {wr, rd, err}); else passed++;
        checks++; if (addr !== 32'h24) $display("FAIL errresp_addr got %h want 00000024", addr); else passed++;
        step();
        checks++; if (err !== 1'b0) $display("FAIL errresp_one_cycle got %b want 0", err); else passed++;
    endtask

    task automatic test_overflow();
        do_reset();
        drive_a(3'd4, 32'h30, 32'h0, 4'h0, 8'd1);
        drive_a(3'd4, 32'h34, 32'h0, 4'h0, 8'd2);
        checks++; if (proto_err !== 1'b0) $display("FAIL ovf_not_yet got %b want 0", proto_err); else passed++;
        drive_a(3'd4, 32'h38, 32'h0, 4'h0, 8'd3);
        checks++; if (outstanding !== 2'd2) $display("FAIL ovf_outstanding got %0d want 2", outstanding); else passed++;
        checks++; if ({proto_err, proto_code} !== 3'b111) $display("FAIL ovf_code got %b want 111", {proto_err, proto_code}); else passed++;
        drive_d(3'd1, 32'h11, 8'd1, 1'b0);
        checks++; if ({rd, addr, rdata} !== {1'b1, 32'h30, 32'h11}) $display("FAIL ovf_rd1 got %b/%h/%h want 1/00000030/00000011", rd, addr, rdata); else passed++;
        drive_d(3'd1, 32'h22, 8'd2, 1'b0);
        checks++; if ({rd, addr, rdata} !== {1'b1, 32'h34, 32'h22}) $display("FAIL ovf_rd2 got %b/%h/%h want 1/00000034/00000022", rd, addr, rdata); else passed++;
        checks++; if (outstanding !== 2'd0) $display("FAIL ovf_drained got %0d want 0", outstanding); else passed++;
    endtask

    task automatic test_unexpected();
        do_reset();
        drive_d(3'd1, 32'h5, 8'd0, 1'b0);
        checks++; if ({wr, rd, err} !== 3'b000) $display("FAIL unexp_no_event got %b want 000", {wr, rd, err}); else passed++;
        checks++; if ({proto_err, proto_code} !== 3'b101) $display("FAIL unexp_code got %b want 101", {proto_err, proto_code}); else passed++;
    endtask

    task automatic test_mismatch();
        do_reset();
        drive_a(3'd4, 32'h50, 32'h0, 4'h0, 8'd5);
        drive_d(3'd1, 32'h77, 8'd6, 1'b0);
        checks++; if (rd !== 1'b0) $display("FAIL mism_src_no_rd got %b want 0", rd); else passed++;
        checks++; if ({proto_err, proto_code} !== 3'b110) $display("FAIL mism_src_code got %b want 110", {proto_err, proto_code}); else passed++;
        checks++; if (outstanding !== 2'd0) $display("FAIL mism_src_popped got %0d want 0", outstanding); else passed++;
        do_reset();
        drive_a(3'd0, 32'h54, 32'h9, 4'h1, 8'd4);
        drive_d(3'd1, 32'h0, 8'd4, 1'b0);
        checks++; if ({wr, proto_code} !== 3'b010) $display("FAIL mism_op got %b want 010", {wr, proto_code}); else passed++;
    endtask

    task automatic test_illegal_and_priority();
        do_reset();
        drive_a(3'd2, 32'h60, 32'h0, 4'h0, 8'd1);
        checks++; if ({outstanding, proto_code} !== 4'b0011) $display("FAIL illegal_op got %b want 0011", {outstanding, proto_code}); else passed++;
        do_reset();
        set_a(3'd2, 32'h64, 32'h0, 4'h0, 8'd1);
        set_d(3'd1, 32'h0, 8'd1, 1'b0);
        step();
        checks++; if (proto_code !== 2'd1) $display("FAIL prio_1_over_3 got %0d want 1", proto_code); else passed++;
    endtask

    task automatic test_back_to_back();
        do_reset();
        drive_a(3'd4, 32'h40, 32'h0, 4'h0, 8'd1);
        drive_a(3'd4, 32'h44, 32'h0, 4'h0, 8'd2);
        set_a(3'd4, 32'h48, 32'h0, 4'h0, 8'd3);
        set_d(3'd1, 32'hA1, 8'd1, 1'b0);
        step();
        checks++; if ({rd, addr, rdata} !== {1'b1, 32'h40, 32'hA1}) $display("FAIL b2b_rd1 got %b/%h/%h want 1/00000040/000000a1", rd, addr, rdata); else passed++;
        checks++; if ({outstanding, proto_err} !== 3'b100) $display("FAIL b2b_full_pushpop got %b want 100", {outstanding, proto_err}); else passed++;
        drive_d(3'd1, 32'hA2, 8'd2, 1'b0);
        checks++; if ({rd, addr} !== {1'b1, 32'h44}) $display("FAIL b2b_rd2 got %b/%h want 1/00000044", rd, addr); else passed++;
        drive_d(3'd1, 32'hA3, 8'd3, 1'b0);
        checks++; if ({rd, addr, rdata} !== {1'b1, 32'h48, 32'hA3}) $display("FAIL b2b_rd3_wrap got %b/%h/%h want 1/00000048/000000a3", rd, addr, rdata); else passed++;
        checks++; if ({outstanding, proto_err} !== 3'b000) $display("FAIL b2b_end got %b want 000", {outstanding, proto_err}); else passed++;
    endtask

    task automatic test_reset_midflight();
        do_reset();
        drive_a(3'd4, 32'h70, 32'h0, 4'h0, 8'd7);
        checks++; if (outstanding !== 2'd1) $display("FAIL rstmid_before got %0d want 1", outstanding); else passed++;
        @(negedge clk);
        rst_n = 0;
        #1;
        checks++; if (outstanding !== 2'd0) $display("FAIL rstmid_cleared got %0d want 0", outstanding); else passed++;
        @(posedge clk); #1 rst_n = 1;
        drive_d(3'd1, 32'h0, 8'd7, 1'b0);
        checks++; if ({rd, proto_err, proto_code} !== 4'b0101) $display("FAIL rstmid_late_resp got %b want 0101", {rd, proto_err, proto_code}); else passed++;
    endtask

    initial begin
        idle_bus();
        rst_n = 0;
        test_reset();
        test_read();
        test_write();
        test_error_resp();
        test_overflow();
        test_unexpected();
        test_mismatch();
        test_illegal_and_priority();
        test_back_to_back();
        test_reset_midflight();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
